// File: rtl/decoder3x8_dispatch.sv
// Sequential 3-to-8 decoder: buffers encoded line indices in a FIFO and drives each as a held one-hot grant.
// Optional macro ACK_TIMEOUT_EN: drops an unacknowledged grant after TIMEOUT cycles and pulses timeout.
module decoder3x8_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_idx,
  output logic                     out_valid,
  output logic [7:0]               out_onehot,
  input  logic                     out_ack,
  output logic                     busy,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  function automatic logic [7:0] decode_idx(input logic [2:0] idx);
    logic [7:0] oh;
    case (idx)
      3'd0:    oh = 8'h01;
      3'd1:    oh = 8'h02;
      3'd2:    oh = 8'h04;
      3'd3:    oh = 8'h08;
      3'd4:    oh = 8'h10;
      3'd5:    oh = 8'h20;
      3'd6:    oh = 8'h40;
      3'd7:    oh = 8'h80;
      default: oh = 8'h00;
    endcase
    return oh;
  endfunction

  logic [2:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  state_t        state_r;
  logic          out_valid_r;
  logic [7:0]    out_onehot_r;

  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic [2:0]    head_s;

  // Handshake and pop decisions; a full FIFO refuses pushes even when popping.
  always_comb begin
    in_ready_s = (count_r < CNT_FULL);
    push_s     = in_valid && in_ready_s;
    pop_s      = (state_r == IDLE) && (count_r != CNT_ZERO);
    head_s     = mem_r[rd_ptr_r];
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 3'd0;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_idx;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_ZERO = TW'(0);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_r;
  logic          timeout_r;

  // Grant FSM with ack hold timer; ack on the expiring edge takes priority over the drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      out_valid_r  <= 1'b0;
      out_onehot_r <= 8'h00;
      timer_r      <= TMR_ZERO;
      timeout_r    <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (count_r != CNT_ZERO) begin
            out_onehot_r <= decode_idx(head_s);
            out_valid_r  <= 1'b1;
            timer_r      <= TMR_ZERO;
            state_r      <= DRIVE;
          end else begin
            out_onehot_r <= 8'h00;
            out_valid_r  <= 1'b0;
          end
        end
        DRIVE: begin
          if (out_ack) begin
            out_onehot_r <= 8'h00;
            out_valid_r  <= 1'b0;
            state_r      <= IDLE;
          end else if (timer_r == TMR_LAST) begin
            out_onehot_r <= 8'h00;
            out_valid_r  <= 1'b0;
            timeout_r    <= 1'b1;
            state_r      <= IDLE;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        default: begin
          out_onehot_r <= 8'h00;
          out_valid_r  <= 1'b0;
          timer_r      <= TMR_ZERO;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign timeout = timeout_r;
`else
  // Grant FSM: a grant is held until the consumer acknowledges it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      out_valid_r  <= 1'b0;
      out_onehot_r <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (count_r != CNT_ZERO) begin
            out_onehot_r <= decode_idx(head_s);
            out_valid_r  <= 1'b1;
            state_r      <= DRIVE;
          end else begin
            out_onehot_r <= 8'h00;
            out_valid_r  <= 1'b0;
          end
        end
        DRIVE: begin
          if (out_ack) begin
            out_onehot_r <= 8'h00;
            out_valid_r  <= 1'b0;
            state_r      <= IDLE;
          end else begin
            out_onehot_r <= out_onehot_r;
            out_valid_r  <= 1'b1;
          end
        end
        default: begin
          out_onehot_r <= 8'h00;
          out_valid_r  <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_onehot = out_onehot_r;
  assign count      = count_r;
  assign busy       = (count_r != CNT_ZERO) || out_valid_r;

endmodule

// File: tb/tb_decoder3x8_dispatch.sv
// Directed self-checking bench for decoder3x8_dispatch (DEPTH=4, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_decoder3x8_dispatch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic       out_valid;
  logic [7:0] out_onehot;
  logic       out_ack;
  logic       busy;
  logic       timeout;
  logic [2:0] count;

  int n_asserts = 0;
  int n_fail    = 0;

  decoder3x8_dispatch #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .out_ack    (out_ack),
    .busy       (busy),
    .timeout    (timeout),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_g [3];
    exp_g[0] = 8'h08;
    exp_g[1] = 8'h08;
    exp_g[2] = 8'h40;

    rst = 1'b0; in_valid = 1'b0; in_idx = 3'd0; out_ack = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_onehot", {24'd0, out_onehot}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single push of idx 5, latency and ack
    in_valid = 1'b1; in_idx = 3'd5;
    tick();
    in_valid = 1'b0;
    check("p5_count", {29'd0, count}, 32'd1);
    check("p5_valid_e", {31'd0, out_valid}, 32'd0);
    tick();
    check("p5_valid_e1", {31'd0, out_valid}, 32'd1);
    check("p5_onehot", {24'd0, out_onehot}, 32'h20);
    check("p5_busy", {31'd0, busy}, 32'd1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("p5_ack_onehot", {24'd0, out_onehot}, 32'h00);
    check("p5_ack_valid", {31'd0, out_valid}, 32'd0);
    check("p5_ack_busy", {31'd0, busy}, 32'd0);

    // Ack with no grant active is ignored
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("idle_ack_valid", {31'd0, out_valid}, 32'd0);
    check("idle_ack_count", {29'd0, count}, 32'd0);

    // Back-to-back pushes: 7 is granted at once, 0,3,3,6 fill the FIFO
    in_valid = 1'b1; in_idx = 3'd7; tick();
    in_idx = 3'd0; tick();
    check("b2b_grant7", {24'd0, out_onehot}, 32'h80);
    in_idx = 3'd3; tick();
    in_idx = 3'd3; tick();
    in_idx = 3'd6; tick();
    check("full_count", {29'd0, count}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_idx = 3'd2; tick();
    check("full_refuse_count", {29'd0, count}, 32'd4);
    check("full_hold_grant", {24'd0, out_onehot}, 32'h80);
    out_ack = 1'b1; tick();
    out_ack = 1'b0;
    check("full_gap_valid", {31'd0, out_valid}, 32'd0);
    check("full_gap_count", {29'd0, count}, 32'd4);
    tick();
    in_valid = 1'b0;
    check("full_pop_refuse", {29'd0, count}, 32'd3);
    check("grant_0", {24'd0, out_onehot}, 32'h01);
    for (int i = 0; i < 3; i++) begin
      out_ack = 1'b1; tick();
      out_ack = 1'b0;
      check("grant_gap", {31'd0, out_valid}, 32'd0);
      tick();
      check("grant_seq", {24'd0, out_onehot}, {24'd0, exp_g[i]});
    end
    out_ack = 1'b1; tick();
    out_ack = 1'b0;
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_count", {29'd0, count}, 32'd0);
    tick();
    check("drain_no_stray", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-DRIVE with two entries queued
    in_valid = 1'b1; in_idx = 3'd1; tick();
    in_idx = 3'd4; tick();
    in_idx = 3'd5; tick();
    in_valid = 1'b0;
    check("pre_rst_count", {29'd0, count}, 32'd2);
    check("pre_rst_grant", {24'd0, out_onehot}, 32'h02);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_onehot", {24'd0, out_onehot}, 32'h00);
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end
    check("post_rst_count", {29'd0, count}, 32'd0);

`ifdef ACK_TIMEOUT_EN
    // Unacknowledged grant is dropped after 16 cycles
    in_valid = 1'b1; in_idx = 3'd2; tick();
    in_valid = 1'b0; tick();
    for (int i = 0; i < 15; i++) begin
      check("to_hold_onehot", {24'd0, out_onehot}, 32'h04);
      check("to_hold_pulse", {31'd0, timeout}, 32'd0);
      tick();
    end
    check("to_last_onehot", {24'd0, out_onehot}, 32'h04);
    tick();
    check("to_drop_valid", {31'd0, out_valid}, 32'd0);
    check("to_pulse", {31'd0, timeout}, 32'd1);
    tick();
    check("to_pulse_end", {31'd0, timeout}, 32'd0);

    // Ack on the expiring edge wins over the timeout
    in_valid = 1'b1; in_idx = 3'd2; tick();
    in_valid = 1'b0; tick();
    for (int i = 0; i < 15; i++) tick();
    check("ack16_onehot", {24'd0, out_onehot}, 32'h04);
    out_ack = 1'b1; tick();
    out_ack = 1'b0;
    check("ack16_valid", {31'd0, out_valid}, 32'd0);
    check("ack16_no_pulse", {31'd0, timeout}, 32'd0);
`else
    // Without the timer a grant is held indefinitely
    in_valid = 1'b1; in_idx = 3'd6; tick();
    in_valid = 1'b0; tick();
    for (int i = 0; i < 100; i++) begin
      check("hold_onehot", {24'd0, out_onehot}, 32'h40);
      check("hold_timeout", {31'd0, timeout}, 32'd0);
      tick();
    end
    out_ack = 1'b1; tick();
    out_ack = 1'b0;
    check("hold_release", {31'd0, out_valid}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
